// File: rtl/ascon_pack.sv
// Shared ASCON types, round constants, rotation amounts and the bitsliced S-box layer.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int ROUND_MAX = 12;

    localparam int unsigned ROT_A [0:4] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [0:4] = '{28, 39, 6, 17, 41};

    function automatic logic is_legal_rounds(input logic [3:0] n);
        return (n == 4'd6) || (n == 4'd8) || (n == 4'd12);
    endfunction

    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // 64 parallel 5-bit S-boxes, evaluated bitsliced across the five words.
    function automatic type_state substitution_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        type_state   r;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0;
        r[1] = x1;
        r[2] = x2;
        r[3] = x3;
        r[4] = x4;
        return r;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, substitution layer, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] round_idx,
    output type_state  result
);

    type_state added;
    type_state substituted;

    always_comb begin
        added          = state;
        added[2][7:0]  = state[2][7:0] ^ round_constant(round_idx);
        substituted    = substitution_layer(added);
        result         = substituted;
        for (int k = 0; k < 5; k++) begin
            result[k] = substituted[k]
                      ^ rotr(substituted[k], ROT_A[k])
                      ^ rotr(substituted[k], ROT_B[k]);
        end
    end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation core: owns the 320-bit state and applies one round per edge,
// or two chained rounds per edge when ASCON_DOUBLE_ROUND_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i with a legal round count; state_o holds the last result
// RUN   | applying rounds round_o.. until round 11 has been applied
module ascon_permutation
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] rounds_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef ASCON_DOUBLE_ROUND_EN
    localparam logic [3:0] STEP = 4'd2;
`else
    localparam logic [3:0] STEP = 4'd1;
`endif
    // Base index of the edge whose rounds end with round 11.
    localparam logic [3:0] LAST_BASE = 4'(ROUND_MAX) - STEP;

    logic [0:0] fsm;
    type_state  state_reg;
    logic [3:0] round_q;
    logic       done_q;

    type_state  round_src;
    logic [3:0] round_base;
    type_state  round_mid;
    type_state  round_next;

    // In IDLE the first round(s) are applied straight to state_i on the accepting edge.
    assign round_src  = (fsm == ST_IDLE) ? state_i : state_reg;
    assign round_base = (fsm == ST_IDLE) ? 4'(ROUND_MAX) - rounds_i : round_q;

    ascon_round u_round0 (
        .state     (round_src),
        .round_idx (round_base),
        .result    (round_mid)
    );

`ifdef ASCON_DOUBLE_ROUND_EN
    ascon_round u_round1 (
        .state     (round_mid),
        .round_idx (round_base + 4'd1),
        .result    (round_next)
    );
`else
    assign round_next = round_mid;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm       <= ST_IDLE;
            state_reg <= '0;
            round_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start_i && is_legal_rounds(rounds_i)) begin
                        state_reg <= round_next;
                        round_q   <= round_base + STEP;
                        fsm       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_reg <= round_next;
                    if (round_q == LAST_BASE) begin
                        done_q  <= 1'b1;
                        round_q <= '0;
                        fsm     <= ST_IDLE;
                    end else begin
                        round_q <= round_q + STEP;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_reg;
    assign busy_o  = (fsm == ST_RUN);
    assign done_o  = done_q;
    assign round_o = round_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboard bench for ascon_permutation: randomized starts checked against a table-driven
// ASCON model; a separate monitor pops expectations whenever done_o pulses.
module tb_ascon_permutation;
    import ascon_pack::*;

`ifdef ASCON_DOUBLE_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic       clock_i;
    logic       reset_i;
    logic       start_i;
    logic [3:0] rounds_i;
    type_state  state_i;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] round_o;

    ascon_permutation dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .round_o  (round_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    typedef struct {
        logic [319:0] st;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [319:0] last_state = '0;

    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] ror(input logic [63:0] v, input int a);
        return (v >> a) | (v << (64 - a));
    endfunction

    // Reference: rounds first..11 using the S-box lookup table column by column.
    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int first);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        logic [319:0] r;
        for (int k = 0; k < 5; k++) x[k] = s_in[k*64 +: 64];
        for (int rnd = first; rnd < 12; rnd++) begin
            x[2] = x[2] ^ 64'((15 - rnd) * 16 + rnd);
            for (int i = 0; i < 64; i++) begin
                col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
                o = sbox_tab[col];
                y[0][i] = o[4];
                y[1][i] = o[3];
                y[2][i] = o[2];
                y[3][i] = o[1];
                y[4][i] = o[0];
            end
            for (int k = 0; k < 5; k++) x[k] = y[k] ^ ror(y[k], rot_a[k]) ^ ror(y[k], rot_b[k]);
        end
        for (int k = 0; k < 5; k++) r[k*64 +: 64] = x[k];
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int rand_legal();
        case ($urandom_range(0, 2))
            0:       return 6;
            1:       return 8;
            default: return 12;
        endcase
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clock_i) begin
        if (!reset_i && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 320'(done_o), 320'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_state", state_o, e.st);
                chk("done_cycle", 320'(cyc), 320'(e.cyc));
                chk("busy_at_done", 320'(busy_o), 320'(0));
            end
        end
    end

    task automatic run_perm(input logic [319:0] s, input int n, input bit hold);
        int c0;
        int lat;
        int exp_round;
        c0  = 12 - n;
        lat = n / STEP;
        state_i  = s;
        rounds_i = 4'(n);
        start_i  = 1'b1;
        last_state = model_perm(s, c0);
        sb.push_back('{last_state, cyc + lat});
        for (int j = 1; j <= lat; j++) begin
            tick();
            exp_round = (j < lat) ? c0 + STEP * j : 0;
            chk("round_seq", 320'(round_o), 320'(exp_round));
            chk("busy_seq", 320'(busy_o), 320'(j < lat));
            if (hold && j < lat) begin
                state_i  = rand320();
                rounds_i = 4'(rand_legal());
            end else begin
                start_i = 1'b0;
            end
        end
    endtask

    // Asynchronous reset landing mid-cycle, with start_i also requested during reset.
    task automatic async_reset();
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_state", state_o, 320'(0));
        chk("rst_busy", 320'(busy_o), 320'(0));
        chk("rst_done", 320'(done_o), 320'(0));
        chk("rst_round", 320'(round_o), 320'(0));
        sb.delete();
        last_state = '0;
        start_i  = 1'b1;
        rounds_i = 4'd12;
        state_i  = rand320();
        tick();
        tick();
        chk("rst_start_ignored", 320'(busy_o), 320'(0));
        start_i = 1'b0;
        reset_i = 1'b0;
    endtask

    initial begin
        logic [319:0] iv_state;
        int ill [5];
        ill = '{5, 13, 0, 7, 15};
        iv_state = '0;
        iv_state[63:0] = 64'h80400c0600000000;

        reset_i  = 1'b1;
        start_i  = 1'b0;
        rounds_i = 4'd0;
        state_i  = '0;
        tick();
        tick();
        chk("init_state", state_o, 320'(0));
        chk("init_busy", 320'(busy_o), 320'(0));
        chk("init_done", 320'(done_o), 320'(0));
        chk("init_round", 320'(round_o), 320'(0));
        reset_i = 1'b0;
        tick();

        run_perm(iv_state, 12, 1'b0);
        tick();
        run_perm(iv_state, 6, 1'b0);
        tick();
        run_perm(iv_state, 8, 1'b0);
        tick();

        // Back-to-back p12: each start lands in the done cycle of the previous one.
        for (int i = 0; i < 3; i++) run_perm(rand320(), 12, 1'b0);
        tick();

        run_perm(rand320(), 12, 1'b1);
        tick();
        tick();
        chk("hold_no_restart", 320'(busy_o), 320'(0));

        foreach (ill[i]) begin
            start_i  = 1'b1;
            rounds_i = 4'(ill[i]);
            state_i  = rand320();
            tick();
            start_i = 1'b0;
            chk("illegal_busy", 320'(busy_o), 320'(0));
            chk("illegal_state", state_o, last_state);
            chk("illegal_round", 320'(round_o), 320'(0));
            tick();
            chk("illegal_done", 320'(done_o), 320'(0));
        end

        // Reset in cycle t+5 of a p12 run.
        state_i  = rand320();
        rounds_i = 4'd12;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        chk("pre_reset_busy", 320'(busy_o), 320'(1));
        for (int j = 0; j < 4; j++) tick();
        async_reset();
        tick();
        run_perm(rand320(), 12, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            run_perm(rand320(), rand_legal(), 1'b0);
        end

        for (int j = 0; j < 3; j++) tick();
        chk("scoreboard_drained", 320'(sb.size()), 320'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
